token_fifo_n: RTL
=================

Name: token_fifo_n

Overview:
- Parametrised, data-less (zero-width) FIFO: tracks an occupancy count of tokens up to DEPTH entries.
- Provides ENQ/DEQ/CLR handshakes, registered FULL_N/EMPTY_N, occupancy count and almost-full indication.
- Used for credit tracking and for pairing with external data storage in BSV-generated and hand-written datapaths.
- Generalises the single-entry token FIFO to arbitrary depth, adding a count output, a threshold flag and an optional unguarded enqueue-while-full mode.

Parameters:
- DEPTH, 4, maximum tokens held; legal range 1..65535.
- CNT_W, 3, width of COUNT; must satisfy 2^CNT_W > DEPTH.
- AFULL_LVL, 3, ALMOST_FULL asserts when count >= AFULL_LVL; legal range 1..DEPTH.
- GUARDED, 1:
  - 1: ENQ while full is illegal and ignored.
  - 0: ENQ while full is accepted when DEQ is asserted in the same cycle.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- ENQ  input  1  enqueue one token this cycle.
- DEQ  input  1  dequeue one token this cycle.
- CLR  input  1  synchronous clear to empty.
- FULL_N  output  1  registered; 1 = space available.
- EMPTY_N  output  1  registered; 1 = at least one token held.
- COUNT  output  CNT_W  registered occupancy, 0..DEPTH.
- ALMOST_FULL  output  1  registered; COUNT >= AFULL_LVL.
- ERR_OVF  output  1  sticky overflow flag (optional feature).
- ERR_UNF  output  1  sticky underflow flag (optional feature).

Behaviour:
- Reset:
  - RST low asynchronously forces COUNT=0, EMPTY_N=0, FULL_N=1, ALMOST_FULL=0, ERR_OVF=0, ERR_UNF=0.
  - Reset takes effect mid-operation; no token survives it.
- Effective dequeue: deq_ok = DEQ & EMPTY_N. Dequeue from empty is ignored.
- Effective enqueue: enq_ok = ENQ & (FULL_N | (!GUARDED & DEQ & EMPTY_N)).
- Next count, evaluated in priority order:
  - CLR: 0 (CLR overrides ENQ and DEQ).
  - enq_ok & deq_ok: unchanged.
  - enq_ok: COUNT+1.
  - deq_ok: COUNT-1.
  - otherwise: hold.
- Flag derivation: FULL_N, EMPTY_N and ALMOST_FULL are registered from next-count compares (next==DEPTH, next!=0, next>=AFULL_LVL). No combinational path from any input to any output.
- Latency: ENQ into an empty FIFO gives EMPTY_N=1 on the following cycle. No bypass: ENQ&DEQ while empty leaves COUNT=1 and drops the DEQ.
- Full, GUARDED=1: ENQ&DEQ at COUNT=DEPTH gives COUNT=DEPTH-1; the ENQ is dropped.
- Full, GUARDED=0: ENQ&DEQ at COUNT=DEPTH keeps COUNT=DEPTH.
- DEPTH=1: must reduce exactly to single-entry token-FIFO behaviour, with FULL_N == !EMPTY_N at all times.
- Count never wraps: saturates logically at 0 and DEPTH because illegal operations are dropped.
- Simulation-only checks (excluded from synthesis), active only while RST is high; each prints a warning including the instance path:
  - DEQ while empty.
  - ENQ while !FULL_N and (!DEQ or GUARDED).

Optional Feature:
- Macro: TOKEN_FIFO_ERR_FLAGS_EN.
- Defined:
  - ERR_OVF sets, one cycle later, on any ENQ dropped because the FIFO is full.
  - ERR_UNF sets, one cycle later, on any DEQ while empty.
  - Both are sticky until CLR or reset; CLR in the same cycle as an error clears the flag (CLR wins).
- Undefined: ERR_OVF and ERR_UNF are constant 0, with no flops inferred; all other behaviour is identical.

Test Plan:
- Reset then idle, DEPTH=4 -> COUNT=0, EMPTY_N=0, FULL_N=1, ALMOST_FULL=0. Assert RST low mid-fill at COUNT=2 -> all outputs return to reset values immediately, without waiting for a clock edge.
- 4 back-to-back ENQ -> COUNT 1,2,3,4; ALMOST_FULL rises with COUNT=3; FULL_N=0 at COUNT=4. Fifth ENQ -> COUNT stays 4, warning printed, ERR_OVF=1 if macro defined.
- At COUNT=4, ENQ&DEQ with GUARDED=1 -> COUNT=3. Same stimulus with GUARDED=0 -> COUNT=4, no warning.
- Empty FIFO, ENQ&DEQ same cycle -> COUNT=1, ERR_UNF=1 with macro. DEQ alone on empty -> COUNT=0, ERR_UNF=1 with macro, 0 without.
- COUNT=3, CLR&ENQ&DEQ -> COUNT=0, EMPTY_N=0, sticky flags cleared. DEPTH=1 build -> alternate ENQ/DEQ each cycle, FULL_N == !EMPTY_N every cycle.

Source files
------------

// File: rtl/token_fifo_n.sv
// token_fifo_n
// Data-less FIFO that tracks how many tokens it holds, up to DEPTH. Used for
// credit tracking or alongside external data storage.
//
// Parameters:
//   DEPTH      maximum tokens held (1..65535)
//   CNT_W      width of COUNT; 2**CNT_W must exceed DEPTH
//   AFULL_LVL  ALMOST_FULL threshold (1..DEPTH)
//   GUARDED    1: ENQ while full is dropped
//              0: ENQ while full is accepted if a DEQ happens in the same cycle
//
// Ports:
//   CLK          clock, rising edge
//   RST          asynchronous active-low reset
//   ENQ/DEQ      add/remove one token this cycle
//   CLR          synchronous clear to empty; overrides ENQ and DEQ
//   FULL_N       registered, 1 = space available
//   EMPTY_N      registered, 1 = at least one token held
//   COUNT        registered occupancy
//   ALMOST_FULL  registered, COUNT >= AFULL_LVL
//   ERR_OVF      sticky dropped-enqueue flag
//   ERR_UNF      sticky dequeue-while-empty flag
//
// Optional feature macro: TOKEN_FIFO_ERR_FLAGS_EN. When it is defined,
// ERR_OVF and ERR_UNF are sticky error flops that CLR or reset clears. When it
// is undefined, both outputs are tied to 0 and no flops are built.
//
// Handshake: an ENQ or DEQ pulse is one request in its cycle. The FIFO takes
// it only when the registered flags allow it. Requests that are not taken are
// dropped and are not held over to later cycles.

module token_fifo_n #(
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 3,
  parameter int AFULL_LVL = 3,
  parameter int GUARDED   = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENQ,
  input  logic             DEQ,
  input  logic             CLR,
  output logic             FULL_N,
  output logic             EMPTY_N,
  output logic [CNT_W-1:0] COUNT,
  output logic             ALMOST_FULL,
  output logic             ERR_OVF,
  output logic             ERR_UNF
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_LVL);
  localparam bit               UNGUARDED = (GUARDED == 0);

  logic [CNT_W-1:0] count_q, count_d;
  logic             full_n_q, full_n_d;
  logic             empty_n_q, empty_n_d;
  logic             afull_q, afull_d;
  logic             deq_ok, enq_ok;

  // In unguarded mode a full FIFO can still take an ENQ, because the DEQ in
  // the same cycle frees a slot.
  assign deq_ok = DEQ & empty_n_q;
  assign enq_ok = ENQ & (full_n_q | (UNGUARDED & DEQ & empty_n_q));

  always_comb begin
    count_d = count_q;
    if (CLR)                  count_d = '0;
    else if (enq_ok & deq_ok) count_d = count_q;
    else if (enq_ok)          count_d = count_q + CNT_W'(1);
    else if (deq_ok)          count_d = count_q - CNT_W'(1);
    // The flags are registered from the next count. This keeps every input
    // off any combinational path to an output.
    full_n_d  = (count_d != DEPTH_C);
    empty_n_d = (count_d != '0);
    afull_d   = (count_d >= AFULL_C);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_q   <= '0;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
      afull_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      full_n_q  <= full_n_d;
      empty_n_q <= empty_n_d;
      afull_q   <= afull_d;
    end
  end

  assign COUNT       = count_q;
  assign FULL_N      = full_n_q;
  assign EMPTY_N     = empty_n_q;
  assign ALMOST_FULL = afull_q;

`ifdef TOKEN_FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // CLR wins over an error raised in the same cycle.
  always_comb begin
    ovf_d = ovf_q | (ENQ & ~enq_ok);
    unf_d = unf_q | (DEQ & ~empty_n_q);
    if (CLR) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ERR_OVF = ovf_q;
  assign ERR_UNF = unf_q;
`else
  assign ERR_OVF = 1'b0;
  assign ERR_UNF = 1'b0;
`endif

`ifndef SYNTHESIS
  // Warnings for illegal use. They are only checked while out of reset.
  always @(posedge CLK) begin
    if (RST) begin
      if (DEQ && !empty_n_q)
        $warning("%m: DEQ while empty");
      if (ENQ && !full_n_q && (!DEQ || !UNGUARDED))
        $warning("%m: ENQ while full");
    end
  end
`endif

endmodule
